// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef logic [7:0] Byte_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } ArbState_t;

  localparam int UART_ARB_CNT_WIDTH = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker: first set req bit above last, with wrap
module rr_priority_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         pick,
  output logic                 any
);

  localparam int LW = $clog2(N);

  logic [LW:0]  rot_amt;
  logic [N-1:0] rot_req;
  logic [N-1:0] rot_pick;

  // Rotate so that position last+1 lands at bit 0, isolate the lowest set bit, rotate back.
  assign rot_amt  = {1'b0, last} + 1'b1;
  assign rot_req  = N'({req, req} >> rot_amt);
  assign rot_pick = rot_req & (~rot_req + 1'b1);
  assign pick     = N'(({rot_pick, rot_pick} << rot_amt) >> N);
  assign any      = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message arbiter onto the UART TX FIFO write port
// Optional per-requester byte counters on byte_count when UART_ARB_STATS_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  input  logic                 fifo_full,
  output logic [7:0]           fifo_din,
  output logic                 fifo_wr_en
`ifdef UART_ARB_STATS_EN
  ,
  output logic [16*N_REQ-1:0]  byte_count
`endif
);

  localparam int LW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  ArbState_t      state;
  logic [LW-1:0]  last_grant;
  logic [LW-1:0]  owner_idx;
  logic [CW-1:0]  burst_cnt;
  logic [N_REQ-1:0] pick;
  logic           any_req;
  logic           slot_open;
  logic           own_valid;
  logic           own_last;
  Byte_t          own_data;
  logic           accept;
  logic           release_now;

  rr_priority_picker #(.N(N_REQ)) u_picker (
    .req  (req_valid),
    .last (last_grant),
    .pick (pick),
    .any  (any_req)
  );

  // Waiting out the cycle after a write keeps a registered fifo_full from being overrun.
  assign slot_open = (state == ARB_BUSY) && !fifo_full && !fifo_wr_en;
  assign req_ready = slot_open ? grant : '0;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    owner_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
        owner_idx = LW'(i);
      end
    end
  end

  assign accept      = slot_open && own_valid;
  assign release_now = accept && (own_last || (burst_cnt == CW'(MAX_BURST - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= 8'h00;
      burst_cnt  <= '0;
      last_grant <= LW'(N_REQ - 1);
    end else begin
      fifo_wr_en <= accept;
      if (accept) begin
        fifo_din <= own_data;
      end
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant     <= pick;
            burst_cnt <= '0;
            state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // The grant is held across owner gaps; only a last byte or the cap releases it.
          if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (release_now) begin
              state      <= ARB_IDLE;
              grant      <= '0;
              last_grant <= owner_idx;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef UART_ARB_STATS_EN
  logic [UART_ARB_CNT_WIDTH-1:0] cnt [N_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && grant[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    byte_count = '0;
    for (int i = 0; i < N_REQ; i++) byte_count[16*i +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter (N_REQ=2, MAX_BURST=4)
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        fifo_full;
  logic [7:0]  fifo_din;
  logic        fifo_wr_en;
`ifdef UART_ARB_STATS_EN
  logic [31:0] byte_count;
`endif

  uart_tx_arbiter #(.N_REQ(2), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant      (grant),
    .fifo_full  (fifo_full),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en)
`ifdef UART_ARB_STATS_EN
    ,
    .byte_count (byte_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int bp_bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         acc_src[$];
  logic [1:0] glog[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] wd(input int i);
    return (i < wr_data.size()) ? {24'h0, wr_data[i]} : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] wc(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] asrc(input int i);
    return (i < acc_src.size()) ? acc_src[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] gl(input int i);
    return (i < glog.size()) ? {30'h0, glog[i]} : 32'hFFFF_FFFF;
  endfunction

  task automatic drive();
    req_valid = {q1.size() != 0, q0.size() != 0};
    req_data  = '0;
    req_last  = '0;
    if (q0.size() != 0) begin
      req_data[7:0] = q0[0][7:0];
      req_last[0]   = q0[0][8];
    end
    if (q1.size() != 0) begin
      req_data[15:8] = q1[0][7:0];
      req_last[1]    = q1[0][8];
    end
  endtask

  task automatic tick();
    logic [1:0] acc;
    logic [8:0] tmp;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc[0] && q0.size() != 0) begin tmp = q0.pop_front(); acc_src.push_back(0); end
    if (acc[1] && q1.size() != 0) begin tmp = q1.pop_front(); acc_src.push_back(1); end
    if (fifo_wr_en) begin
      wr_data.push_back(fifo_din);
      wr_cyc.push_back(cyc);
    end
    glog.push_back(grant);
    drive();
  endtask

  task automatic begin_test();
    rst       = 1'b1;
    fifo_full = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_data.delete();
    wr_cyc.delete();
    acc_src.delete();
    glog.delete();
    cyc = 0;
    glog.push_back(grant);
  endtask

  initial begin
    int exp_d[6];
    int exp_s[6];
    rst       = 1'b1;
    fifo_full = 1'b0;
    drive();
    @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);

    // single requester, three bytes
    begin_test();
    q0 = '{9'h041, 9'h042, 9'h143};
    drive();
    repeat (8) tick();
    check("t1_nwr", wr_data.size(), 3);
    check("t1_d0", wd(0), 'h41);
    check("t1_d1", wd(1), 'h42);
    check("t1_d2", wd(2), 'h43);
    check("t1_c0", wc(0), 2);
    check("t1_gap01", wc(1) - wc(0), 2);
    check("t1_gap12", wc(2) - wc(1), 2);
    check("t1_grant1", gl(1), 1);
    check("t1_grant_end", gl(6), 0);

    // contention: req0 first, req1 after the release gap
    begin_test();
    q0 = '{9'h0A0, 9'h1A1};
    q1 = '{9'h0B0, 9'h1B1};
    drive();
    repeat (10) tick();
    check("t2_d0", wd(0), 'hA0);
    check("t2_d1", wd(1), 'hA1);
    check("t2_d2", wd(2), 'hB0);
    check("t2_d3", wd(3), 'hB1);
    check("t2_c1", wc(1), 4);
    check("t2_c3", wc(3), 8);
    check("t2_gap_idle", gl(4), 0);
    check("t2_grant_r1", gl(5), 2);

    // round robin with one-byte messages
    begin_test();
    q0 = '{9'h110, 9'h111, 9'h112, 9'h113};
    q1 = '{9'h120, 9'h121, 9'h122, 9'h123};
    drive();
    repeat (17) tick();
    check("t3_nwr", wr_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_d%0d", i), wd(i), ((i % 2) ? 'h20 : 'h10) + i / 2);
      check($sformatf("t3_s%0d", i), asrc(i), i % 2);
    end

    // burst cap of 4 while req0 waits
    begin_test();
    q1 = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039};
    drive();
    tick();
    q0 = '{9'h150};
    drive();
    repeat (11) tick();
    exp_d = '{'h30, 'h31, 'h32, 'h33, 'h50, 'h34};
    exp_s = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t4_d%0d", i), wd(i), exp_d[i]);
      check($sformatf("t4_s%0d", i), asrc(i), exp_s[i]);
    end
    check("t4_rel_idle", gl(8), 0);
    check("t4_grant_r0", gl(9), 1);

    // backpressure for 20 cycles mid-message
    begin_test();
    q0 = '{9'h060, 9'h061, 9'h162};
    drive();
    repeat (3) tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready !== 2'b00 || fifo_wr_en !== 1'b0 || grant !== 2'b01) bp_bad++;
      if (k < 19) tick();
    end
    fifo_full = 1'b0;
    repeat (4) tick();
    check("t5_bp_viol", bp_bad, 0);
    check("t5_d0", wd(0), 'h60);
    check("t5_d1", wd(1), 'h61);
    check("t5_c1", wc(1), 23);
    check("t5_d2", wd(2), 'h62);
    check("t5_c2", wc(2), 25);
    check("t5_grant_end", gl(25), 0);

    // reset mid-message
    begin_test();
    q0 = '{9'h070, 9'h071, 9'h072, 9'h073, 9'h174};
    drive();
    repeat (5) tick();
    check("t6_nwr_pre", wr_data.size(), 2);
    rst = 1'b1;
    tick();
    check("t6_grant", grant, 0);
    check("t6_ready", req_ready, 0);
    check("t6_wr_en", fifo_wr_en, 0);
    check("t6_din", fifo_din, 0);
    check("t6_nwr_rst", wr_data.size(), 2);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    drive();
`ifdef UART_ARB_STATS_EN
    check("t6_bc_rst", byte_count, 0);
`endif
    q1 = '{9'h080, 9'h081, 9'h182};
    drive();
    repeat (8) tick();
    check("t6_d2", wd(2), 'h80);
    check("t6_d4", wd(4), 'h82);
    check("t6_s4", asrc(4), 1);
`ifdef UART_ARB_STATS_EN
    check("t6_bc1", byte_count[31:16], 3);
    check("t6_bc0", byte_count[15:0], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit FIFO write port among `N_REQ` byte-stream requesters, for example the CPU bus slave path and a hardware debug/trace source. It sits between the requesters and the transmit FIFO write side of the UART controller, in the `base_2x` clock domain. Grants are held for a whole message, delimited by `req_last`, so lines from different sources never interleave. A burst cap bounds starvation.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, 2..8.
- `MAX_BURST`, default 64: maximum bytes accepted per grant, 1..255.

Ports:
- `clk` in 1: single clock, the UART `base_2x` domain.
- `rst` in 1: reset. **Synchronous, active-high.**
- `req_valid` in `N_REQ`: requester i presents a byte.
- `req_data` in `8*N_REQ`: byte for requester i at bits `[8i+7:8i]`.
- `req_last` in `N_REQ`: the byte presented is the final byte of a message.
- `req_ready` out `N_REQ`: byte accepted this cycle when `valid & ready`.
- `grant` out `N_REQ`: one-hot current owner; all zero when idle.
- `fifo_full` in 1: transmit FIFO full flag.
- `fifo_din` out 8: FIFO write data.
- `fifo_wr_en` out 1: FIFO write strobe, one cycle per byte.
- `byte_count` out `16*N_REQ`: per-requester sent-byte counters. Present only with `UART_ARB_STATS_EN`.

## Operation
State machine with two states, `ARB_IDLE` and `ARB_BUSY`.

`ARB_IDLE`:
- If any `req_valid` is high, pick the first set bit scanning upward from `(last_grant+1) mod N_REQ`, with wrap.
- Register the pick as `grant` and `owner`, clear `burst_cnt`, go to `ARB_BUSY`.
- If no `req_valid` is high, stay in `ARB_IDLE`.

`ARB_BUSY`:
- `req_ready[owner] = !fifo_full && !fifo_wr_en`. All other `req_ready` bits are 0.
- The `!fifo_wr_en` term forbids back-to-back writes, so a registered `fifo_full` can never be overrun.
- On acceptance: `fifo_din <= req_data[owner]`, `fifo_wr_en <= 1` on the next edge, `burst_cnt <= burst_cnt+1`.
- Release to `ARB_IDLE` after the accepted byte when `req_last[owner]` is 1 or `burst_cnt+1 == MAX_BURST`. On release, `last_grant <= owner` and `grant <= 0`.
- If the owner drops `req_valid` mid-message, the grant is held. The lock persists until a `last` byte or the cap.
- `req_last` is ignored on non-accepted cycles.

Widths and arithmetic:
- `burst_cnt` is `$clog2(MAX_BURST+1)` bits. It never wraps because release occurs at `MAX_BURST`.
- `last_grant` is `$clog2(N_REQ)` bits.

Reset, applied at any time including mid-message:
- State `ARB_IDLE`, `grant = 0`, `req_ready = 0`, `fifo_wr_en = 0`, `fifo_din = 8'h00`, `burst_cnt = 0`.
- `last_grant = N_REQ-1`, so requester 0 has first priority.
- A partially sent message is abandoned. No byte is written during the reset cycle.

## Timing
- Arbitration takes 1 cycle: `req_valid` seen in `ARB_IDLE` at edge k gives `grant` valid and `ARB_BUSY` in cycle k+1.
- `req_ready` is combinational from state, `fifo_full` and `fifo_wr_en`. It is never a function of `req_valid`.
- Write latency is 1 cycle: a byte accepted in cycle t produces `fifo_wr_en` and `fifo_din` in cycle t+1.
- Throughput is at most 1 byte per 2 cycles per grant.
- The release gap is at least 1 idle cycle: after release, the next grant appears 2 cycles after the last acceptance.
- `fifo_full` asserted: `req_ready` stays 0 and the grant is held indefinitely.

## Configuration
- `UART_ARB_STATS_EN` defined:
  - Instantiates per-requester 16-bit counters exposed on `byte_count`.
  - A counter increments on each accepted byte from that requester and saturates at `16'hFFFF`.
  - Counters clear only on `rst`.
- `UART_ARB_STATS_EN` undefined:
  - The `byte_count` port and the counters are absent.
  - All other behaviour is identical.

## Structure
- Shared package `uart_arb_pkg`:
  - `ArbState_t` enum `{ARB_IDLE, ARB_BUSY}`.
  - `UART_ARB_CNT_WIDTH = 16`.
- `Byte_t` comes from the common definitions.
- Sub-module `rr_priority_picker`: parameter `N`; inputs `req[N-1:0]` and `last[$clog2(N)-1:0]`; outputs one-hot `pick` and `any`. Combinational, reusable by other arbiters.

## Test plan
- Single requester: req0 sends 3 bytes `0x41, 0x42, 0x43` with `last` on `0x43` -> `fifo_wr_en` pulses 3 times, 2 cycles apart, data in order, then `grant = 0`.
- Contention: req0 and req1 valid together after reset, each sending a 2-byte message -> req0 served first; req1 granted 2 cycles after req0's last byte; no interleaving.
- Round-robin: both requesters continuously sending 1-byte messages -> grants alternate 0, 1, 0, 1; each requester receives 50% of writes.
- Burst cap: `MAX_BURST = 4`, req1 sends 10 bytes with no `last` while req0 is waiting -> req1 gets 4 bytes, then req0 is granted.
- Backpressure: hold `fifo_full = 1` for 20 cycles mid-message -> `req_ready = 0`, no `fifo_wr_en`, grant held; the byte resumes 1 cycle after `fifo_full` falls.
- Reset mid-message, plus stats: assert `rst` after 2 of 5 bytes -> all outputs return to reset values next cycle. With `UART_ARB_STATS_EN`, counters read 0 after reset; after 3 bytes from req1, `byte_count[31:16] = 3`.
